// File: rtl/vmul_pkg.sv
// vmul_pkg: op encodings, FSM state type and group-count helper for the vector multiply unit
package vmul_pkg;
  localparam logic [1:0] VMUL_LO_S = 2'b00;
  localparam logic [1:0] VMUL_LO_U = 2'b01;
  localparam logic [1:0] VMUL_HI_S = 2'b10;
  localparam logic [1:0] VMUL_HI_U = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DRAIN, ST_DONE} state_t;
  function automatic int num_groups(input int lanes, input int mul_lanes);
    return (lanes + mul_lanes - 1) / mul_lanes;
  endfunction
endpackage

// File: rtl/vmul_lane_mul.sv
// vmul_lane_mul: one WIDTH x WIDTH multiplier with signedness, hi/lo select and optional rounding shift
//   a, b  : element operands
//   op    : [1]=high half, [0]=unsigned
//   shamt : fixed-point shift, only used when VMUL_FXP_ROUND_EN is defined
//   y     : selected WIDTH-bit result
module vmul_lane_mul
  import vmul_pkg::*;
#(
  parameter int LOG2WIDTH = 5,
  localparam int WIDTH = 2 ** LOG2WIDTH
) (
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           op,
  input  logic [LOG2WIDTH-1:0] shamt,
  output logic [WIDTH-1:0]     y
);
  logic signed [2*WIDTH-1:0] ea, eb;
  logic [2*WIDTH-1:0] p;
  // extend to 2*WIDTH so a single signed multiply covers both signednesses
  assign ea = op[0] ? {{WIDTH{1'b0}}, a} : {{WIDTH{a[WIDTH-1]}}, a};
  assign eb = op[0] ? {{WIDTH{1'b0}}, b} : {{WIDTH{b[WIDTH-1]}}, b};
  assign p = ea * eb;
`ifdef VMUL_FXP_ROUND_EN
  logic signed [2*WIDTH:0] pe, rnd;
  // one guard bit keeps the rounding add from overflowing
  assign pe = {op[0] ? 1'b0 : p[2*WIDTH-1], p};
  assign rnd = (shamt != '0) ? (2*WIDTH+1)'(1) << (shamt - 1'b1) : '0;
  assign y = op[1] ? p[2*WIDTH-1:WIDTH] : WIDTH'((pe + rnd) >>> shamt);
`else
  logic unused_shamt;
  assign unused_shamt = ^shamt;
  assign y = op[1] ? p[2*WIDTH-1:WIDTH] : p[WIDTH-1:0];
`endif
endmodule

// File: rtl/vmul_seq_unit.sv
// vmul_seq_unit: time-multiplexed vector multiply, NUMLANES lanes on NUMMULLANES multipliers
//   in_valid/in_ready accept an op (op, opA, opB, vmask, vshamt, in_dst, in_dst_we)
//   out_valid/out_ready hand back result with out_dst, out_dst_we, out_dst_mask
//   squash aborts in any state; resetn is async active-low
//   VMUL_FXP_ROUND_EN adds rounding shift on low-half ops and one extra cycle of latency
module vmul_seq_unit
  import vmul_pkg::*;
#(
  parameter int LOG2WIDTH   = 5,
  parameter int NUMLANES    = 16,
  parameter int NUMMULLANES = 4,
  parameter int REGIDWIDTH  = 4,
  localparam int WIDTH = 2 ** LOG2WIDTH
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                op,
  input  logic [NUMLANES*WIDTH-1:0] opA,
  input  logic [NUMLANES*WIDTH-1:0] opB,
  input  logic [NUMLANES-1:0]       vmask,
  input  logic [LOG2WIDTH-1:0]      vshamt,
  input  logic [REGIDWIDTH-1:0]     in_dst,
  input  logic                      in_dst_we,
  input  logic                      squash,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUMLANES*WIDTH-1:0] result,
  output logic [REGIDWIDTH-1:0]     out_dst,
  output logic                      out_dst_we,
  output logic [NUMLANES-1:0]       out_dst_mask
);
  localparam int NG = num_groups(NUMLANES, NUMMULLANES);
  localparam int GW = NG > 1 ? $clog2(NG) : 1;
  localparam int PL = NG * NUMMULLANES;
  localparam int GB = NUMMULLANES * WIDTH;
  state_t state, state_nxt;
  logic [NUMLANES*WIDTH-1:0] a_q, b_q, res_nxt;
  logic [1:0] op_q;
  logic [NUMLANES-1:0] mask_q;
  logic [NG-1:0] pend, pend_nxt, grp_init;
  logic [GW-1:0] sel, wr_grp;
  logic [PL*WIDTH-1:0] a_pad, b_pad;
  logic [PL-1:0] vmask_pad;
  logic [GB-1:0] ga, gb, gy, wr_y;
  logic [LOG2WIDTH-1:0] shamt_src;
  logic accept, mul_go, wr_v;
  assign in_ready = state == ST_IDLE;
  assign out_valid = state == ST_DONE;
  assign accept = in_valid && in_ready && !squash;
  // pad to whole groups so lanes past NUMLANES-1 see zero operands
  assign a_pad = (PL*WIDTH)'(a_q);
  assign b_pad = (PL*WIDTH)'(b_q);
  assign vmask_pad = PL'(vmask);
  always_comb begin
    grp_init = '0;
    for (int g = 0; g < NG; g++) grp_init[g] = |vmask_pad[g*NUMMULLANES +: NUMMULLANES];
  end
  // lowest pending group wins; groups with no enabled lanes were never pending
  always_comb begin
    sel = '0;
    for (int g = NG - 1; g >= 0; g--) if (pend[g]) sel = GW'(g);
  end
  assign pend_nxt = pend & ~(NG'(1) << sel);
  assign ga = a_pad[sel*GB +: GB];
  assign gb = b_pad[sel*GB +: GB];
  assign mul_go = state == ST_MUL && |pend && !squash;
  for (genvar j = 0; j < NUMMULLANES; j++) begin : g_mul
    vmul_lane_mul #(.LOG2WIDTH(LOG2WIDTH)) u_mul (
      .a(ga[j*WIDTH +: WIDTH]),
      .b(gb[j*WIDTH +: WIDTH]),
      .op(op_q),
      .shamt(shamt_src),
      .y(gy[j*WIDTH +: WIDTH])
    );
  end
`ifdef VMUL_FXP_ROUND_EN
  localparam state_t ST_LAST = ST_DRAIN;
  logic [LOG2WIDTH-1:0] shamt_q;
  logic pipe_v;
  logic [GW-1:0] pipe_grp;
  logic [GB-1:0] pipe_y;
  assign shamt_src = shamt_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      shamt_q <= '0;
      pipe_v <= 1'b0;
      pipe_grp <= '0;
      pipe_y <= '0;
    end else begin
      if (accept) shamt_q <= vshamt;
      pipe_v <= mul_go;
      pipe_grp <= sel;
      pipe_y <= gy;
    end
  assign wr_v = pipe_v && !squash;
  assign wr_grp = pipe_grp;
  assign wr_y = pipe_y;
`else
  localparam state_t ST_LAST = ST_DONE;
  assign shamt_src = vshamt;
  assign wr_v = mul_go;
  assign wr_grp = sel;
  assign wr_y = gy;
`endif
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = accept ? ST_MUL : ST_IDLE;
      ST_MUL:   state_nxt = (pend_nxt == '0) ? ST_LAST : ST_MUL;
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = out_ready ? ST_IDLE : ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (squash) state_nxt = ST_IDLE;
  end
  always_comb begin
    res_nxt = result;
    for (int k = 0; k < NUMLANES; k++)
      if (wr_v && wr_grp == GW'(k / NUMMULLANES) && mask_q[k])
        res_nxt[k*WIDTH +: WIDTH] = wr_y[(k % NUMMULLANES)*WIDTH +: WIDTH];
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= ST_IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      mask_q <= '0;
      pend <= '0;
      result <= '0;
      out_dst <= '0;
      out_dst_we <= 1'b0;
      out_dst_mask <= '0;
    end else begin
      state <= state_nxt;
      result <= accept ? '0 : res_nxt;
      pend <= accept ? grp_init : pend_nxt;
      if (accept) begin
        a_q <= opA;
        b_q <= opB;
        op_q <= op;
        mask_q <= vmask;
        out_dst <= in_dst;
        out_dst_we <= in_dst_we;
        out_dst_mask <= vmask;
      end
    end
endmodule

// File: tb/tb_vmul_seq_unit.sv
// tb_vmul_seq_unit: directed self-checking bench for vmul_seq_unit (8 lanes, 3 multipliers, 32-bit)
module tb_vmul_seq_unit;
  import vmul_pkg::*;
  localparam int L = 8;
  localparam int W = 32;
  logic clk = 0, resetn = 1, in_valid = 0, out_ready = 0, squash = 0, in_dst_we = 0;
  logic in_ready, out_valid, out_dst_we;
  logic [1:0] op = '0;
  logic [L*W-1:0] opA = '0, opB = '0, result;
  logic [L-1:0] vmask = '0, out_dst_mask;
  logic [4:0] vshamt = '0;
  logic [3:0] in_dst = '0, out_dst;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  vmul_seq_unit #(.LOG2WIDTH(5), .NUMLANES(L), .NUMMULLANES(3), .REGIDWIDTH(4)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .opA(opA), .opB(opB), .vmask(vmask), .vshamt(vshamt), .in_dst(in_dst),
    .in_dst_we(in_dst_we), .squash(squash), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_dst(out_dst), .out_dst_we(out_dst_we), .out_dst_mask(out_dst_mask)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_lanes(input string tag, input logic [L*W-1:0] exp);
    for (int k = 0; k < L; k++) check($sformatf("%s_l%0d", tag, k), 64'(result[k*W +: W]), 64'(exp[k*W +: W]));
  endtask
  task automatic run_op(input logic [L*W-1:0] a, input logic [L*W-1:0] b, input logic [1:0] o,
                        input logic [L-1:0] m, input logic [3:0] d, output int lat);
    @(negedge clk);
    opA = a; opB = b; op = o; vmask = m; in_dst = d; in_dst_we = 1; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0; opA = '0; opB = '0; vmask = '0; in_dst = ~d; in_dst_we = 0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask
  task automatic release_out();
    @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
  endtask
  initial begin
    logic [L*W-1:0] va, vb, ev;
    int lat, bad;
    #2 resetn = 0;
    #1;
    check("rst_in_ready", 64'(in_ready), 1);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_result", 64'(|result), 0);
    check("rst_dst", 64'({out_dst_we, out_dst, out_dst_mask}), 0);
    @(negedge clk) resetn = 1;
    for (int k = 0; k < L; k++) begin
      va[k*W +: W] = 32'(k + 1);
      vb[k*W +: W] = 32'd3;
      ev[k*W +: W] = 32'(3 * (k + 1));
    end
    run_op(va, vb, VMUL_LO_S, 8'hFF, 4'h5, lat);
    check("full_lat", 64'(lat), 3);
    check_lanes("full", ev);
    check("full_dst", 64'(out_dst), 5);
    check("full_dst_we", 64'(out_dst_we), 1);
    check("full_mask", 64'(out_dst_mask), 8'hFF);
    check("full_in_ready", 64'(in_ready), 0);
    release_out();
    check("rel_in_ready", 64'(in_ready), 1);
    check("rel_out_valid", 64'(out_valid), 0);
    for (int k = 3; k < L; k++) ev[k*W +: W] = '0;
    run_op(va, vb, VMUL_LO_S, 8'h07, 4'h2, lat);
    check("m07_lat", 64'(lat), 1);
    check_lanes("m07", ev);
    check("m07_mask", 64'(out_dst_mask), 8'h07);
    release_out();
    run_op(va, vb, VMUL_LO_S, 8'h00, 4'h3, lat);
    check("m00_lat", 64'(lat), 1);
    check_lanes("m00", '0);
    release_out();
    va = {L{32'hFFFF_FFFF}};
    vb = {L{32'd2}};
    run_op(va, vb, VMUL_HI_U, 8'hFF, 4'h1, lat);
    check("hiu_lat", 64'(lat), 3);
    check_lanes("hiu", {L{32'd1}});
    release_out();
    run_op(va, vb, VMUL_HI_S, 8'hFF, 4'h1, lat);
    check_lanes("his", {L{32'hFFFF_FFFF}});
    release_out();
    ev = '0;
    ev[0 +: W] = 32'hFFFF_FFFE;
    ev[6*W +: W] = 32'hFFFF_FFFE;
    run_op(va, vb, VMUL_LO_U, 8'h41, 4'h1, lat);
    check("lou_lat", 64'(lat), 2);
    check_lanes("lou", ev);
    release_out();
    for (int k = 0; k < L; k++) begin
      va[k*W +: W] = 32'(k + 1);
      vb[k*W +: W] = 32'd3;
    end
    @(negedge clk);
    opA = va; opB = vb; op = VMUL_LO_S; vmask = 8'hFF; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0; squash = 1;
    @(posedge clk);
    #1 squash = 0;
    check("sq_in_ready", 64'(in_ready), 1);
    check("sq_out_valid", 64'(out_valid), 0);
    bad = 0;
    repeat (5) begin
      @(posedge clk);
      #1 if (out_valid) bad++;
    end
    check("sq_never_valid", 64'(bad), 0);
    ev = '0;
    for (int k = 0; k < L; k++) begin
      va[k*W +: W] = 32'(k + 2);
      vb[k*W +: W] = 32'hFFFF_FFFD;
      if (k >= 6) ev[k*W +: W] = 32'(-3 * (k + 2));
    end
    run_op(va, vb, VMUL_LO_S, 8'hC0, 4'h9, lat);
    check("post_sq_lat", 64'(lat), 1);
    check_lanes("post_sq", ev);
    check("post_sq_dst", 64'(out_dst), 9);
    release_out();
    for (int k = 0; k < L; k++) begin
      va[k*W +: W] = 32'(k + 1);
      vb[k*W +: W] = 32'd3;
      ev[k*W +: W] = 32'(3 * (k + 1));
    end
    run_op(va, vb, VMUL_LO_S, 8'hFF, 4'hA, lat);
    check("hold_lat", 64'(lat), 3);
    bad = 0;
    repeat (5) begin
      @(posedge clk);
      #1 if (result !== ev || in_ready || !out_valid || out_dst !== 4'hA) bad++;
    end
    check("hold_stable", 64'(bad), 0);
    release_out();
    check("hold_rel_ready", 64'(in_ready), 1);
    for (int k = 3; k < L; k++) ev[k*W +: W] = '0;
    run_op(va, vb, VMUL_LO_S, 8'h07, 4'h6, lat);
    check("back2back_lat", 64'(lat), 1);
    check_lanes("back2back", ev);
    release_out();
    @(negedge clk);
    opA = va; opB = vb; op = VMUL_LO_S; vmask = 8'hFF; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    @(posedge clk);
    #2 resetn = 0;
    #1;
    check("arst_in_ready", 64'(in_ready), 1);
    check("arst_out_valid", 64'(out_valid), 0);
    check_lanes("arst", '0);
    @(negedge clk) resetn = 1;
    bad = 0;
    repeat (5) begin
      @(posedge clk);
      #1 if (out_valid) bad++;
    end
    check("arst_no_valid", 64'(bad), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
